// File: rtl/stream_cat_sync.sv
`default_nettype none
// ============================================================================
// Module   : stream_cat_sync
// Purpose  : Collects one beat per AXI-Stream byte lane, holds it, and emits
//            the concatenated word on one AXI-Stream master with backpressure,
//            lane masking and a partial-word stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
module stream_cat_sync #(
   parameter int N_LANES   = 13,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT_W = 16
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [N_LANES-1:0]          lane_enable,
   input  logic [TIMEOUT_W-1:0]        timeout_cycles,
   input  logic [N_LANES*DATA_W-1:0]   s_axis_tdata,
   input  logic [N_LANES-1:0]          s_axis_tvalid,
   output logic [N_LANES-1:0]          s_axis_tready,
   output logic [N_LANES*DATA_W-1:0]   m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        timeout_pulse,
   output logic [N_LANES-1:0]          stalled_lanes,
   output logic [31:0]                 word_count
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PARTIAL  = 2'd1,
      ST_COMPLETE = 2'd2
   } state_t;

   localparam logic [TIMEOUT_W-1:0] c_to_one = 1;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [N_LANES-1:0]          r_act;
   logic [N_LANES-1:0]          w_act_nxt;
   logic [N_LANES-1:0]          r_full;
   logic [N_LANES-1:0]          w_full_nxt;
   logic [N_LANES-1:0]          w_rdy;
   logic [N_LANES-1:0]          w_cap;
   logic [N_LANES*DATA_W-1:0]   r_hold;
   logic [N_LANES*DATA_W-1:0]   w_hold_masked;
   logic [N_LANES*DATA_W-1:0]   r_m_tdata;
   logic                        r_m_tvalid;
   logic [TIMEOUT_W-1:0]        r_tcnt;
   logic                        r_timeout_pulse;
   logic [N_LANES-1:0]          r_stalled;
   logic [31:0]                 r_word_count;
   logic                        w_all_full;
   logic                        w_fire;
   logic                        w_out_hs;
   logic                        w_flush;

   // An all-zero mask never counts as a complete word
   assign w_all_full = (&(r_full | ~r_act)) & (|r_act);
   assign w_fire     = w_all_full & (~r_m_tvalid | m_axis_tready);
   assign w_out_hs   = r_m_tvalid & m_axis_tready;
   assign w_flush    = (r_state == ST_PARTIAL) && (timeout_cycles != '0) &&
                       (r_tcnt == timeout_cycles - c_to_one);

   // The mask only follows lane_enable while no word is being collected
   assign w_act_nxt  = (r_state == ST_IDLE) ? lane_enable : r_act;

   // Flush drops everything; otherwise a lane stays full if it refills as the word fires
   assign w_full_nxt = w_flush ? '0
                     : ((w_cap | (r_full & ~{N_LANES{w_fire}})) & w_act_nxt);

   // Per-lane ready and capture; inactive lanes always drain
   always_comb begin
      w_rdy = '1;
      w_cap = '0;
      for (int i = 0; i < N_LANES; i++) begin
         if (r_act[i])
            w_rdy[i] = ~w_flush & (~r_full[i] | w_fire);
         w_cap[i] = r_act[i] & s_axis_tvalid[i] & w_rdy[i];
      end
   end

   assign s_axis_tready = aresetn ? w_rdy : '0;

   // Held data with inactive lanes zeroed for the output word
   always_comb begin
      w_hold_masked = '0;
      for (int i = 0; i < N_LANES; i++)
         if (r_act[i])
            w_hold_masked[i*DATA_W +: DATA_W] = r_hold[i*DATA_W +: DATA_W];
   end

   // Next state follows from which active lanes will be holding data
   always_comb begin
      w_state_nxt = ST_IDLE;
      if (|w_full_nxt)
         w_state_nxt = (&(w_full_nxt | ~w_act_nxt)) ? ST_COMPLETE : ST_PARTIAL;
   end

   // State, lane mask and holding registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
         r_act   <= '1;
         r_full  <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_act   <= w_act_nxt;
         r_full  <= w_full_nxt;
         for (int i = 0; i < N_LANES; i++)
            if (w_cap[i])
               r_hold[i*DATA_W +: DATA_W] <= s_axis_tdata[i*DATA_W +: DATA_W];
      end
   end

   // Output register and accepted-word counter
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_m_tvalid   <= 1'b0;
         r_m_tdata    <= '0;
         r_word_count <= '0;
      end else begin
         if (w_fire) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_hold_masked;
         end else if (w_out_hs) begin
            r_m_tvalid <= 1'b0;
         end
         if (w_out_hs)
            r_word_count <= r_word_count + 32'd1;
      end
   end

   // Partial-word stall timer, flush pulse and sticky stalled-lane record
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_tcnt          <= '0;
         r_timeout_pulse <= 1'b0;
         r_stalled       <= '0;
      end else begin
         r_timeout_pulse <= w_flush;
         if (w_flush)
            r_stalled <= r_act & ~r_full;
         if ((r_state == ST_PARTIAL) && (w_state_nxt == ST_PARTIAL))
            r_tcnt <= r_tcnt + c_to_one;
         else
            r_tcnt <= '0;
      end
   end

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tvalid = r_m_tvalid;
   assign timeout_pulse = r_timeout_pulse;
   assign stalled_lanes = r_stalled;
   assign word_count    = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_cat_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_cat_sync
// Purpose  : Self-checking bench for stream_cat_sync: vector table, directed
//            multi-cycle sequences and randomized traffic against a
//            per-lane queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_cat_sync;
   localparam int N  = 13;
   localparam int DW = 8;
   localparam int TW = 16;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [N-1:0]      lane_enable;
   logic [TW-1:0]     timeout_cycles;
   logic [N*DW-1:0]   s_tdata;
   logic [N-1:0]      s_tvalid;
   logic [N-1:0]      s_tready;
   logic [N*DW-1:0]   m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              timeout_pulse;
   logic [N-1:0]      stalled;
   logic [31:0]       word_count;

   int n_pass  = 0;
   int n_total = 0;

   always #5 aclk = ~aclk;

   stream_cat_sync #(.N_LANES(N), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .lane_enable    (lane_enable),
      .timeout_cycles (timeout_cycles),
      .s_axis_tdata   (s_tdata),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tready  (s_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .timeout_pulse  (timeout_pulse),
      .stalled_lanes  (stalled),
      .word_count     (word_count)
   );

   typedef struct {
      logic [N-1:0]    en;
      logic [7:0]      base;
      logic [N*DW-1:0] exp;
   } vec_t;
   vec_t vecs[5];

   // Reference model: each active lane's accepted beats in order; word n is
   // the n-th entry of every active lane, inactive bytes zero.
   logic [7:0]   lq [N][$];
   logic [N-1:0] act_m;
   bit           model_on   = 1'b0;
   int           exp_wc     = 0;
   bit           prev_stall = 1'b0;
   logic [N*DW-1:0] prev_data;
   int           inact_viol = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [N*DW-1:0] ramp(input logic [7:0] base);
      logic [N*DW-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) w[i*DW +: DW] = base + 8'(i);
      return w;
   endfunction

   task automatic model_eval();
      logic [N*DW-1:0] w;
      if (prev_stall) chk("axi_hold", 128'({m_tvalid, m_tdata}), 128'({1'b1, prev_data}));
      if (m_tvalid && m_tready) begin
         w = '0;
         for (int i = 0; i < N; i++)
            if (act_m[i]) begin
               if (lq[i].size() == 0) w[i*DW +: DW] = 'x;
               else w[i*DW +: DW] = lq[i].pop_front();
            end
         chk("word", 128'(m_tdata), 128'(w));
         exp_wc++;
      end
      for (int i = 0; i < N; i++) begin
         if (s_tvalid[i] && s_tready[i] && act_m[i]) lq[i].push_back(s_tdata[i*DW +: DW]);
         if (!act_m[i] && !s_tready[i]) inact_viol++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
   endtask

   task automatic step(input logic [N-1:0] vld, input logic [N*DW-1:0] dat, input logic rdy);
      @(negedge aclk);
      s_tvalid = vld;
      s_tdata  = dat;
      m_tready = rdy;
      #1;
      if (model_on) model_eval();
   endtask

   task automatic set_mask(input logic [N-1:0] en);
      @(negedge aclk);
      lane_enable = en;
      s_tvalid    = '0;
      m_tready    = 1'b1;
      @(negedge aclk);
      act_m = en;
   endtask

   // Feed only lanes with nothing pending until every queued beat has left
   task automatic drain();
      int k;
      bit all_empty;
      logic [N-1:0] v;
      logic [127:0] r;
      k = 0;
      while (k < 60) begin
         v = '0;
         all_empty = 1'b1;
         for (int i = 0; i < N; i++)
            if (act_m[i]) begin
               if (lq[i].size() == 0) v[i] = 1'b1;
               else all_empty = 1'b0;
            end
         if (all_empty && !m_tvalid) break;
         if (all_empty) v = '0;
         r = {$urandom, $urandom, $urandom, $urandom};
         step(v, r[N*DW-1:0], 1'b1);
         k++;
      end
      chk("drain_done", 128'(k < 60), 128'(1));
   endtask

   task automatic rand_phase(input logic [N-1:0] en, input int cycles, input int vpct, input int rpct);
      logic [N-1:0] v;
      logic [127:0] r;
      set_mask(en);
      for (int i = 0; i < N; i++) lq[i].delete();
      inact_viol = 0;
      prev_stall = 1'b0;
      model_on   = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) v[i] = ($urandom_range(99) < vpct);
         r = {$urandom, $urandom, $urandom, $urandom};
         step(v, r[N*DW-1:0], $urandom_range(99) < rpct);
      end
      drain();
      model_on = 1'b0;
      chk("inactive_ready", 128'(inact_viol), 128'(0));
      chk("rand_word_count", 128'(word_count), 128'(exp_wc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int bubbles, pulses, vseen, nrdy, wc0;
      logic [N-1:0] one;
      logic [N*DW-1:0] exp1, exp2;
      one = 1;

      vecs[0] = '{13'h1FFF, 8'h10, 104'h1C1B1A19181716151413121110};
      vecs[1] = '{13'h0005, 8'h10, 104'h120010};
      vecs[2] = '{13'h1000, 8'hA0, {8'hAC, 96'h0}};
      vecs[3] = '{13'h1FFF, 8'hF0, 104'hFCFBFAF9F8F7F6F5F4F3F2F1F0};
      vecs[4] = '{13'h1555, 8'h30, 104'h3C003A00380036003400320030};

      aresetn = 1'b1; lane_enable = '1; timeout_cycles = '0;
      s_tdata = '0; s_tvalid = '0; m_tready = 1'b1; act_m = '1;
      #2 aresetn = 1'b0;
      #10;
      chk("rst_s_tready", 128'(s_tready), 128'(0));
      chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_m_tdata", 128'(m_tdata), 128'(0));
      chk("rst_pulse", 128'(timeout_pulse), 128'(0));
      chk("rst_stalled", 128'(stalled), 128'(0));
      chk("rst_wcount", 128'(word_count), 128'(0));
      @(negedge aclk) aresetn = 1'b1;

      // Single-word assembly under several masks
      for (int t = 0; t < 5; t++) begin
         set_mask(vecs[t].en);
         step('1, ramp(vecs[t].base), 1'b1);
         step('0, '0, 1'b1);
         chk("vec_latency", 128'(m_tvalid), 128'(0));
         step('0, '0, 1'b1);
         chk("vec_valid", 128'(m_tvalid), 128'(1));
         chk("vec_data", 128'(m_tdata), 128'(vecs[t].exp));
         exp_wc++;
         step('0, '0, 1'b1);
         chk("vec_done", 128'(m_tvalid), 128'(0));
         chk("vec_wcount", 128'(word_count), 128'(exp_wc));
      end

      // Staggered lanes, then 5 cycles of downstream backpressure
      set_mask('1);
      exp1 = ramp(8'h40);
      exp2 = ramp(8'h50);
      for (int i = 0; i < N; i++) begin
         step(one << i, exp1, 1'b0);
         if (i > 0) chk("stagger_ready_drop", 128'(s_tready[i-1]), 128'(0));
      end
      step('0, '0, 1'b0);
      chk("stagger_latency", 128'(m_tvalid), 128'(0));
      step('1, exp2, 1'b0);
      chk("bp_first", 128'({m_tvalid, m_tdata}), 128'({1'b1, exp1}));
      for (int k = 0; k < 4; k++) begin
         step('0, '0, 1'b0);
         chk("bp_hold", 128'({m_tvalid, m_tdata}), 128'({1'b1, exp1}));
      end
      chk("bp_ready_low", 128'(s_tready), 128'(0));
      step('0, '0, 1'b1);
      chk("bp_release", 128'({m_tvalid, m_tdata}), 128'({1'b1, exp1}));
      step('0, '0, 1'b1);
      chk("bp_second", 128'({m_tvalid, m_tdata}), 128'({1'b1, exp2}));
      exp_wc += 2;
      step('0, '0, 1'b1);
      chk("bp_done", 128'(m_tvalid), 128'(0));
      chk("bp_wcount", 128'(word_count), 128'(exp_wc));

      // Timeout: lane 12 silent, flush 4 cycles after first capture
      timeout_cycles = 16'd4;
      step(13'h0FFF, ramp(8'h60), 1'b1);
      for (int k = 0; k < 4; k++) begin
         step('0, '0, 1'b1);
         chk("to_no_pulse", 128'(timeout_pulse), 128'(0));
      end
      chk("to_flush_ready", 128'(s_tready[12]), 128'(0));
      step('0, '0, 1'b1);
      chk("to_pulse", 128'(timeout_pulse), 128'(1));
      chk("to_stalled", 128'(stalled), 128'(13'h1000));
      chk("to_no_word", 128'(m_tvalid), 128'(0));
      step('0, '0, 1'b1);
      chk("to_pulse_end", 128'(timeout_pulse), 128'(0));

      // Timeout disabled: partial word waits indefinitely
      timeout_cycles = '0;
      step(13'h0FFF, ramp(8'h60), 1'b1);
      pulses = 0; vseen = 0;
      for (int k = 0; k < 30; k++) begin
         step('0, '0, 1'b1);
         if (timeout_pulse) pulses++;
         if (m_tvalid) vseen++;
      end
      chk("to0_no_pulse", 128'(pulses), 128'(0));
      chk("to0_no_word", 128'(vseen), 128'(0));
      chk("to0_sticky", 128'(stalled), 128'(13'h1000));
      step(13'h1000, ramp(8'h60), 1'b1);
      step('0, '0, 1'b1);
      step('0, '0, 1'b1);
      chk("to0_word", 128'({m_tvalid, m_tdata}), 128'({1'b1, 104'h6C6B6A69686766656463626160}));
      exp_wc++;
      step('0, '0, 1'b1);
      chk("to0_wcount", 128'(word_count), 128'(exp_wc));

      // Asynchronous reset in the middle of a partial word
      step(13'h003F, ramp(8'h70), 1'b1);
      step('0, '0, 1'b1);
      #2 aresetn = 1'b0;
      #1;
      chk("mid_rst_tready", 128'(s_tready), 128'(0));
      chk("mid_rst_tvalid", 128'(m_tvalid), 128'(0));
      chk("mid_rst_tdata", 128'(m_tdata), 128'(0));
      chk("mid_rst_wcount", 128'(word_count), 128'(0));
      chk("mid_rst_stalled", 128'(stalled), 128'(0));
      @(negedge aclk) aresetn = 1'b1;
      exp_wc = 0;
      step(13'h1FC0, ramp(8'h80), 1'b1);
      step('0, '0, 1'b1);
      step('0, '0, 1'b1);
      chk("post_rst_no_stale", 128'(m_tvalid), 128'(0));
      step(13'h003F, ramp(8'h80), 1'b1);
      step('0, '0, 1'b1);
      step('0, '0, 1'b1);
      chk("post_rst_word", 128'({m_tvalid, m_tdata}), 128'({1'b1, 104'h8C8B8A89888786858483828180}));
      exp_wc++;
      step('0, '0, 1'b1);
      chk("post_rst_wcount", 128'(word_count), 128'(exp_wc));

      // Randomized traffic against the queue model
      rand_phase('1, 300, 70, 70);
      rand_phase(13'h0005, 200, 60, 50);
      rand_phase(13'($urandom_range(8191, 1)), 300, 80, 60);

      // Full-rate streaming: 100 words, no bubbles
      set_mask('1);
      for (int i = 0; i < N; i++) lq[i].delete();
      prev_stall = 1'b0;
      model_on = 1'b1;
      wc0 = int'(word_count);
      bubbles = 0;
      for (int c = 0; c < 103; c++) begin
         if (c < 100) step('1, ramp(8'(c)), 1'b1);
         else step('0, '0, 1'b1);
         if (c >= 2 && c <= 101 && !m_tvalid) bubbles++;
      end
      model_on = 1'b0;
      chk("stream_bubbles", 128'(bubbles), 128'(0));
      chk("stream_count", 128'(int'(word_count) - wc0), 128'(100));

      // Empty mask: lanes drain, no word ever forms
      set_mask('0);
      wc0 = int'(word_count);
      vseen = 0; nrdy = 0;
      for (int c = 0; c < 20; c++) begin
         step(13'($urandom), {4{$urandom}}, 1'b1);
         if (m_tvalid) vseen++;
         if (s_tready != '1) nrdy++;
      end
      chk("mask0_no_word", 128'(vseen), 128'(0));
      chk("mask0_ready", 128'(nrdy), 128'(0));
      chk("mask0_wcount", 128'(word_count), 128'(wc0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_cat_sync.md
# stream_cat_sync

Word-assembly controller for the lane-concatenation datapath: collects one beat from each of `N_LANES` AXI-Stream byte lanes and emits the concatenated word on a single AXI-Stream master with full handshake. The concatenator it replaces is always-ready and does no sequencing; this block adds per-lane holding, backpressure, lane masking and stall timeout. It sits between the per-channel deserializers and the wide packet builder.

## Interface
- `N_LANES`, 13: number of input lanes.
- `DATA_W`, 8: bits per lane.
- `TIMEOUT_W`, 16: width of the timeout counter and `timeout_cycles`.

- `aclk`  in  1  sole clock; all logic is rising-edge.
- `aresetn`  in  1  asynchronous active-low reset.
- `lane_enable`  in  N_LANES  requested lane mask; bit i enables lane i.
- `timeout_cycles`  in  TIMEOUT_W  partial-word timeout; 0 disables the timeout.
- `s_axis_tdata`  in  N_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- `s_axis_tvalid`  in  N_LANES  per-lane valid.
- `s_axis_tready`  out  N_LANES  per-lane ready.
- `m_axis_tdata`  out  N_LANES*DATA_W  assembled word, same lane order.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `timeout_pulse`  out  1  one-cycle pulse when a partial word is flushed.
- `stalled_lanes`  out  N_LANES  active lanes still missing at the last timeout; sticky until the next timeout.
- `word_count`  out  32  number of accepted output words; wraps modulo 2^32.

## Operation
- **Active mask `act`**: a register, reset to all ones. It is loaded from `lane_enable` only in state IDLE. Changes made during PARTIAL take effect after the word fires or is flushed.
- **Per-lane holding**: each lane has a holding register `hold[i]` and a flag `full[i]`.
  - Lane handshake: `s_axis_tvalid[i] & s_axis_tready[i]` captures data into `hold[i]` and sets `full[i]`.
- **Readiness**:
  - `all_full` = `&(full | ~act)`, and is true only if `act != 0`.
  - `fire` = `all_full & (~m_axis_tvalid | m_axis_tready)`.
  - Active lane: `s_axis_tready[i]` = `~full[i] | fire`. This is a combinational path from `m_axis_tready` and is intended.
  - Inactive lane: `s_axis_tready[i]` = 1. Beats on inactive lanes are drained and discarded.
- **On `fire`**:
  - `m_axis_tdata` ← `hold`, with inactive lanes forced to 0.
  - `m_axis_tvalid` ← 1.
  - Each `full[i]` is cleared unless lane i handshakes in the same cycle, in which case `full[i]` stays 1 with the new data.
- **Output**: an output handshake without `fire` clears `m_axis_tvalid`. `word_count` increments on every output handshake.
- **FSM, for timeout only**:
  - IDLE: no active lane is full.
  - PARTIAL: at least one active lane is full and `all_full` is 0.
  - COMPLETE: `all_full` is 1, awaiting `fire`.
  - Transitions:
    - IDLE→PARTIAL on the first capture.
    - PARTIAL→COMPLETE when the last lane fills.
    - COMPLETE→IDLE or PARTIAL on `fire`, depending on same-cycle captures.
    - PARTIAL→IDLE on flush.
- **Timeout**:
  - The counter runs only in PARTIAL and clears on leaving PARTIAL.
  - When `timeout_cycles != 0` and the counter equals `timeout_cycles - 1`:
    - assert `timeout_pulse`;
    - latch `stalled_lanes` ← `act & ~full`;
    - clear all `full` (flush; data is lost);
    - go to IDLE.
  - A capture in the flush cycle is discarded; `s_axis_tready` is forced to 0 for active lanes during the flush cycle.
  - COMPLETE never times out, whatever the downstream backpressure.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `s_axis_tready`=0 while `aresetn`=0, `timeout_pulse`=0, `stalled_lanes`=0, `word_count`=0, all `full`=0, state IDLE.
- Latency: the last lane handshake at edge k gives `m_axis_tvalid`=1 after edge k+1.
- Throughput: one word per cycle when all lanes are valid every cycle and `m_axis_tready`=1.
- AXI rule: `m_axis_tdata` is stable while `m_axis_tvalid` is high and `m_axis_tready` is low.
- Timeout: a flush occurs exactly `timeout_cycles` cycles after entering PARTIAL.
- Reset mid-operation discards held data and the pending output immediately (asynchronous reset).

## Test plan
- **Basic assembly**: `act`=all, each lane i sends 8'h10+i in one cycle → one word `m_axis_tdata`=0x1C1B…1110 one cycle later, `word_count`=1.
- **Staggered lanes with backpressure**: lane i arrives at cycle i and `m_axis_tready`=0 for 5 cycles → `tdata` holds steady; each lane's `tready` drops after its capture; a second word is accepted only after the output handshake.
- **Lane mask**: `lane_enable`=0x0005 loaded in IDLE; lanes 1,3–12 toggle randomly → their `tready`=1 and their data is discarded; output lanes other than 0 and 2 read 0. `lane_enable`=0 → no words are ever emitted.
- **Timeout**: `timeout_cycles`=4, lanes 0–11 send and lane 12 is silent → `timeout_pulse` exactly 4 cycles after the first capture, `stalled_lanes`=0x1000, no output word. With `timeout_cycles`=0 → waits indefinitely.
- **Streaming**: all lanes valid for 100 cycles with `m_axis_tready`=1 → 100 consecutive words, `word_count`=100, no bubbles.
- **Reset mid-word**: assert `aresetn`=0 while in PARTIAL → all outputs return to reset values; the next full word assembles correctly.
